// File: rtl/vga_fb_arbiter.sv
// Framebuffer arbiter: display cell fetches in fixed x-locked slots, CPU writes in the remaining cycles.
// Build option FB_VBLANK_WR_ONLY_EN: CPU writes are accepted only during vertical blanking.
module vga_fb_arbiter #(
  parameter int H_ACTIVE = 640,
  parameter int H_TOTAL  = 800,
  parameter int V_TOTAL  = 525,
  parameter int V_ACTIVE = 480,
  parameter int COLS     = 80,
  parameter int ROWS     = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pxl_en,
  input  logic [9:0]  x,
  input  logic [10:0] y,
  input  logic        wr_req,
  input  logic [12:0] wr_addr,
  input  logic [2:0]  wr_data,
  output logic        wr_ack,
  output logic [12:0] mem_addr,
  output logic        mem_we,
  output logic [2:0]  mem_wdata,
  input  logic [2:0]  mem_rdata,
  output logic        r,
  output logic        g,
  output logic        b
);

  // state  | meaning
  // S_IDLE | RAM port unused this cycle
  // S_DISP | display fetch address on the RAM port
  // S_WR   | CPU write on the RAM port, wr_ack high
  typedef enum logic [1:0] {S_IDLE, S_DISP, S_WR} state_t;

  localparam logic [9:0]  X_LAST      = 10'(H_TOTAL - 1);
  localparam logic [9:0]  X_WRAP      = 10'(H_TOTAL - 2);
  localparam logic [9:0]  X_FETCH_END = 10'(H_ACTIVE - 8);
  localparam logic [10:0] Y_LAST      = 11'(V_TOTAL - 1);
  localparam logic [10:0] Y_ACT       = 11'(V_ACTIVE);
  localparam logic [12:0] COLS_W      = 13'(COLS);
  localparam logic [12:0] N_CELLS     = 13'(COLS * ROWS);

  state_t      state_q, state_d;
  logic [12:0] mem_addr_q, mem_addr_d;
  logic        mem_we_q, mem_we_d;
  logic [2:0]  mem_wdata_q, mem_wdata_d;
  logic        cap_q;
  logic [2:0]  cur_cell_q;
  logic [2:0]  rgb_q;

  logic [9:0]  x_nxt;
  logic [10:0] y_nxt;
  logic        slot_col, slot_wrap, wr_ok;
  logic [12:0] disp_addr;

  // Slot decisions look one pixel ahead because the RAM port is registered.
  always_comb begin
    x_nxt     = (x == X_LAST) ? 10'd0 : x + 10'd1;
    y_nxt     = (y == Y_LAST) ? 11'd0 : y + 11'd1;
    slot_col  = (x_nxt[2:0] == 3'd6) && (x_nxt < X_FETCH_END) && (y < Y_ACT);
    slot_wrap = (x_nxt == X_WRAP) && (y_nxt < Y_ACT);
    if (slot_wrap) begin
      disp_addr = {5'd0, y_nxt[10:3]} * COLS_W;
    end else begin
      disp_addr = {5'd0, y[10:3]} * COLS_W + {6'd0, x_nxt[9:3]} + 13'd1;
    end
  end

`ifdef FB_VBLANK_WR_ONLY_EN
  assign wr_ok = wr_req && (y >= Y_ACT);
`else
  assign wr_ok = wr_req;
`endif

  always_comb begin
    state_d     = S_IDLE;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    if (slot_col || slot_wrap) begin
      state_d    = S_DISP;
      mem_addr_d = disp_addr;
    end else if (wr_ok && (state_q != S_WR)) begin
      state_d     = S_WR;
      mem_addr_d  = wr_addr;
      mem_wdata_d = wr_data;
      mem_we_d    = (wr_addr < N_CELLS);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      mem_addr_q  <= 13'd0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= 3'd0;
      cap_q       <= 1'b0;
      cur_cell_q  <= 3'd0;
      rgb_q       <= 3'd0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      cap_q       <= (state_q == S_DISP);
      if (cap_q) begin
        cur_cell_q <= mem_rdata;
      end
      rgb_q       <= pxl_en ? cur_cell_q : 3'b000;
    end
  end

  assign wr_ack    = (state_q == S_WR);
  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign r         = rgb_q[2];
  assign g         = rgb_q[1];
  assign b         = rgb_q[0];

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: jumpable sync counters, synchronous RAM model and a golden cell map.
module tb_vga_fb_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pxl_en;
  logic [9:0]  x = 10'd0;
  logic [10:0] y = 11'd0;
  logic        wr_req;
  logic [12:0] wr_addr;
  logic [2:0]  wr_data;
  logic        wr_ack;
  logic [12:0] mem_addr;
  logic        mem_we;
  logic [2:0]  mem_wdata;
  logic [2:0]  mem_rdata = 3'd0;
  logic        r, g, b;

  logic        jmp = 1'b0;
  logic [9:0]  jx = 10'd0;
  logic [10:0] jy = 11'd0;
  logic [2:0]  fb   [0:8191];
  logic [2:0]  gold [0:4799];
  logic        pix_chk = 1'b0;
  logic        mon_en  = 1'b0;
  logic        ack_q   = 1'b0;
  int n_tests = 0, n_fail = 0, sb_tests = 0, sb_fail = 0, mon_tests = 0, mon_fail = 0;

  typedef struct packed {
    logic [12:0] addr;
    logic [2:0]  data;
    logic        we;
  } wr_exp_t;
  wr_exp_t    wq[$];
  logic [2:0] pq[$];

  vga_fb_arbiter dut (
    .clk(clk), .rst(rst), .pxl_en(pxl_en), .x(x), .y(y),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .r(r), .g(g), .b(b)
  );

  always #5 clk = ~clk;

  assign pxl_en = (x < 10'd640) && (y < 11'd480);

  function automatic logic [2:0] pat(input int i);
    return 3'((i * 5 + (i / 80) * 3) % 8);
  endfunction

  function automatic logic is_slot(input int xv, input int yv);
    int yn = (yv == 524) ? 0 : yv + 1;
    return ((xv % 8 == 6) && (xv < 632) && (yv < 480)) || ((xv == 798) && (yn < 480));
  endfunction

  function automatic int disp_addr(input int xv, input int yv);
    int yn = (yv == 524) ? 0 : yv + 1;
    if (xv == 798) return (yn / 8) * 80;
    return (yv / 8) * 80 + xv / 8 + 1;
  endfunction

  // Sync generator with a one-shot position jump to skip whole frames.
  always @(posedge clk) begin
    if (jmp) begin
      x <= jx;
      y <= jy;
    end else if (x == 10'd799) begin
      x <= 10'd0;
      y <= (y == 11'd524) ? 11'd0 : y + 11'd1;
    end else begin
      x <= x + 10'd1;
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 8192; i++) fb[i] <= pat(i);
    end else if (mem_we) begin
      fb[mem_addr] <= mem_wdata;
    end
    mem_rdata <= fb[mem_addr];
  end

  always @(posedge clk) begin : pix_sb
    logic [2:0] e;
    if (pix_chk) begin
      if (pxl_en) pq.push_back(gold[(int'(y) / 8) * 80 + int'(x) / 8]);
      else        pq.push_back(3'b000);
    end
    #1;
    if (pq.size() > 0) begin
      e = pq.pop_front();
      sb_tests++;
      assert ({r, g, b} === e) else begin
        sb_fail++;
        $error("FAIL pixel x=%0d y=%0d: observed %b expected %b", x, y, {r, g, b}, e);
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      mon_tests++;
      assert (!(wr_ack && ack_q)) else begin
        mon_fail++;
        $error("FAIL ack_b2b x=%0d y=%0d: observed two consecutive acks, expected gap", x, y);
      end
      if (is_slot(int'(x), int'(y))) begin
        mon_tests++;
        assert (mem_we === 1'b0 && mem_addr === 13'(disp_addr(int'(x), int'(y)))) else begin
          mon_fail++;
          $error("FAIL slot x=%0d y=%0d: observed we=%b addr=%0d expected we=0 addr=%0d",
                 x, y, mem_we, mem_addr, disp_addr(int'(x), int'(y)));
        end
      end
    end
    ack_q <= wr_ack;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic jump(input int xv, input int yv);
    @(negedge clk);
    jx = 10'(xv);
    jy = 11'(yv);
    jmp = 1'b1;
    @(negedge clk);
    jmp = 1'b0;
  endtask

  task automatic wait_pos(input int xv, input int yv);
    bit hit = 1'b0;
    for (int i = 0; i < 5000 && !hit; i++) begin
      @(negedge clk);
      if (int'(x) == xv && int'(y) == yv) hit = 1'b1;
    end
    check($sformatf("reach_x%0d_y%0d", xv, yv), 16'(hit), 16'd1);
  endtask

  task automatic raise_req(input logic [12:0] a, input logic [2:0] d);
    wr_exp_t e;
    e.addr = a;
    e.data = d;
    e.we   = (a < 13'd4800);
    wq.push_back(e);
    wr_addr = a;
    wr_data = d;
    wr_req  = 1'b1;
  endtask

  task automatic wait_ack(input string tag, input bit drop, output int cyc);
    wr_exp_t e;
    bit hit = 1'b0;
    cyc = 0;
    while (!hit && cyc < 40) begin
      @(negedge clk);
      cyc++;
      hit = (wr_ack === 1'b1);
    end
    check({tag, "_ack"}, 16'(hit), 16'd1);
    e = wq.pop_front();
    if (hit) begin
      check({tag, "_addr"}, 16'(mem_addr), 16'(e.addr));
      check({tag, "_we"}, 16'(mem_we), 16'(e.we));
      check({tag, "_wdata"}, 16'(mem_wdata), 16'(e.data));
      if (e.we) gold[e.addr] = e.data;
    end
    if (drop) wr_req = 1'b0;
  endtask

  initial begin
    int cyc;
    bit seen;
    wr_req  = 1'b0;
    wr_addr = 13'd0;
    wr_data = 3'd0;
    for (int i = 0; i < 4800; i++) gold[i] = pat(i);

    rst = 1'b0;
    raise_req(13'd0, 3'b100);
    jump(700, 524);
    repeat (3) @(negedge clk);
    check("rst_r", 16'(r), 16'd0);
    check("rst_g", 16'(g), 16'd0);
    check("rst_b", 16'(b), 16'd0);
    check("rst_ack", 16'(wr_ack), 16'd0);
    check("rst_we", 16'(mem_we), 16'd0);
    check("rst_addr", 16'(mem_addr), 16'd0);
    check("rst_wdata", 16'(mem_wdata), 16'd0);

    rst = 1'b1;
    mon_en = 1'b1;
    pix_chk = 1'b1;
    wait_ack("first", 1'b1, cyc);
    check("first_ack_noslot", 16'(is_slot(int'(x), int'(y))), 16'd0);
    raise_req(13'd1, 3'b010);
    wait_ack("fill1", 1'b1, cyc);
    raise_req(13'd80, 3'b001);
    wait_ack("fill80", 1'b1, cyc);

    wait_pos(1, 0);
    check("l0_x0_rgb", 16'({r, g, b}), 16'(3'b100));
    wait_pos(6, 0);
    check("l0_slot_addr", 16'(mem_addr), 16'd1);
    check("l0_slot_we", 16'(mem_we), 16'd0);
    wait_pos(8, 0);
    check("l0_x7_rgb", 16'({r, g, b}), 16'(3'b100));
    wait_pos(9, 0);
    check("l0_x8_rgb", 16'({r, g, b}), 16'(3'b010));
    wait_pos(16, 0);
    check("l0_x15_rgb", 16'({r, g, b}), 16'(3'b010));

    jump(700, 7);
    wait_pos(798, 7);
    check("wrap_addr", 16'(mem_addr), 16'd80);
    check("wrap_we", 16'(mem_we), 16'd0);
    wait_pos(1, 8);
    check("wrap_rgb", 16'({r, g, b}), 16'(3'b001));

`ifndef FB_VBLANK_WR_ONLY_EN
    wait_pos(5, 10);
    raise_req(13'd4000, 3'b111);
    @(negedge clk);
    check("cf_slot_we", 16'(mem_we), 16'd0);
    check("cf_slot_addr", 16'(mem_addr), 16'd81);
    check("cf_slot_noack", 16'(wr_ack), 16'd0);
    wait_ack("cf", 1'b1, cyc);
    check("cf_ack_latency", 16'(cyc), 16'd1);
    check("cf_ack_x", 16'(x), 16'd7);
    @(negedge clk);
    check("cf_no_second_ack", 16'(wr_ack), 16'd0);
`else
    jump(700, 100);
    raise_req(13'd4001, 3'b011);
    seen = 1'b0;
    repeat (300) begin
      @(negedge clk);
      if (wr_ack === 1'b1) seen = 1'b1;
    end
    check("vb_stall", 16'(seen), 16'd0);
    jump(700, 479);
    wait_pos(0, 480);
    wait_ack("vb", 1'b1, cyc);
    check("vb_ack_within_2", 16'(cyc <= 2), 16'd1);
`endif

    jump(700, 399);
    wait_pos(0, 401);
    jump(700, 478);
    wait_pos(798, 479);
    check("vb_edge_addr", 16'(mem_addr), 16'd4799);
    check("vb_edge_we", 16'(mem_we), 16'd0);

    jump(100, 500);
    raise_req(13'd3205, 3'b110);
    wait_ack("b2b0", 1'b0, cyc);
    raise_req(13'd3206, 3'b011);
    wait_ack("b2b1", 1'b1, cyc);
    check("b2b_gap", 16'(cyc), 16'd2);
    @(negedge clk);
    check("ram_3205", 16'(fb[3205]), 16'(3'b110));
    check("ram_3206", 16'(fb[3206]), 16'(3'b011));

    raise_req(13'd4800, 3'b101);
    wait_ack("oor", 1'b1, cyc);
    @(negedge clk);
    check("oor_ram", 16'(fb[4800]), 16'(pat(4800)));

    repeat (5) @(negedge clk);
    pix_chk = 1'b0;
    mon_en = 1'b0;
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests + sb_tests + mon_tests, n_fail + sb_fail + mon_fail);
    $finish;
  end

endmodule
